// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: filler instruction, reset vector default
// and the fetch sequencer state encoding.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_WORD     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_STOP = 3'd4
  } fetch_state_e;

  function automatic logic misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, one outstanding word read,
// valid/ready hand-off to decode, redirect/trap with stale-read drop.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_exc_misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         discard_q, discard_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         valid_q, valid_d;
  logic         exc_q, exc_d;
  logic         armed_q, armed_d;

  logic         redir;
  logic [31:0]  tgt;
  logic         read_open;
  logic         launch;
  logic [31:0]  launch_pc;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      discard_q <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
      exc_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      exc_q     <= exc_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    exc_d     = exc_q;
    armed_d   = armed_q | (im_req & im_gnt);
    launch    = 1'b0;
    launch_pc = pc_q;
    redir     = trap | redirect;
    tgt       = trap ? trap_pc : redirect_pc;
    read_open = (state_q == ST_REQ) ||
                ((state_q == ST_WAIT) && !im_rvalid);

    unique case (state_q)
      ST_IDLE: launch = 1'b1;
      ST_REQ: begin
        if (im_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (im_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            launch    = 1'b1;
          end else begin
            inst_d    = im_rdata;
            inst_pc_d = pc_q;
            exc_d     = 1'b0;
            valid_d   = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          valid_d = 1'b0;
          if (exc_q) begin
            state_d = ST_STOP;
          end else begin
            launch    = 1'b1;
            launch_pc = pc_q + 32'd4;
          end
        end
      end
      ST_STOP: ;
      default: state_d = ST_IDLE;
    endcase

    // An open read keeps its address; its response is dropped later.
    if (redir) begin
      pc_d    = tgt;
      valid_d = 1'b0;
      if (read_open) begin
        discard_d = 1'b1;
        launch    = 1'b0;
      end else begin
        launch    = 1'b1;
        launch_pc = tgt;
      end
    end

    if (launch) begin
      pc_d = launch_pc;
      if (misaligned(launch_pc)) begin
        state_d   = ST_HOLD;
        inst_d    = NOP_INST;
        inst_pc_d = launch_pc;
        exc_d     = 1'b1;
        valid_d   = 1'b1;
      end else begin
        state_d = ST_REQ;
        addr_d  = launch_pc;
        valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    im_req              = (state_q == ST_REQ);
    im_addr             = addr_q;
    inst_valid          = valid_q;
    inst                = inst_q;
    inst_pc             = inst_pc_q;
    inst_exc_misaligned = exc_q;
  end

  // Responses from before a reset may still trickle in until a new grant.
  a_rvalid_in_wait: assert property (
    @(posedge clk) disable iff (!resetb)
    (im_rvalid && armed_q) |-> (state_q == ST_WAIT)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized
// run checked against a program-order PC model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetb;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [31:0] trap_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_exc_misaligned;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int          gnt_pct;
  int          lat_min;
  int          lat_max;
  bit          m_busy;
  int          m_wait;
  logic [31:0] m_addr;

  bit          s_req, s_gnt, s_hs, s_valid, s_exc;
  logic [31:0] s_addr, s_inst, s_pc;

  instruction_fetch dut (
    .clk                 (clk),
    .resetb              (resetb),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .trap                (trap),
    .trap_pc             (trap_pc),
    .im_req              (im_req),
    .im_addr             (im_addr),
    .im_gnt              (im_gnt),
    .im_rvalid           (im_rvalid),
    .im_rdata            (im_rdata),
    .inst_valid          (inst_valid),
    .inst_ready          (inst_ready),
    .inst                (inst),
    .inst_pc             (inst_pc),
    .inst_exc_misaligned (inst_exc_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock: memory responds, inputs applied, outputs snapshotted.
  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc,
                      input bit tr, input logic [31:0] tpc);
    im_gnt    = 1'b0;
    im_rvalid = 1'b0;
    im_rdata  = $urandom;
    if (m_busy) begin
      if (m_wait == 0) begin
        im_rvalid = 1'b1;
        im_rdata  = mem_word(m_addr);
        m_busy    = 1'b0;
      end else begin
        m_wait--;
      end
    end
    if (im_req && !m_busy && (int'($urandom_range(99)) < gnt_pct)) begin
      im_gnt = 1'b1;
      m_busy = 1'b1;
      m_addr = im_addr;
      m_wait = int'($urandom_range(lat_max, lat_min));
    end
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    trap        = tr;
    trap_pc     = tpc;
    s_req   = im_req;
    s_addr  = im_addr;
    s_gnt   = im_gnt;
    s_valid = inst_valid;
    s_hs    = inst_valid && rdy;
    s_inst  = inst;
    s_pc    = inst_pc;
    s_exc   = inst_exc_misaligned;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    redirect = 0; redirect_pc = 0; trap = 0; trap_pc = 0;
    im_gnt = 0; im_rvalid = 0; im_rdata = 0; inst_ready = 0;
    m_busy = 0; m_wait = 0; m_addr = 0;
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (im_req !== 1'b0) begin
      bad++; $display("FAIL rst_req got=%b want=0", im_req);
    end
    total++;
    if (im_addr !== 32'h0) begin
      bad++; $display("FAIL rst_addr got=%h want=0", im_addr);
    end
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b want=0", inst_valid);
    end
    total++;
    if (inst !== NOP) begin
      bad++; $display("FAIL rst_inst got=%h want=%h", inst, NOP);
    end
    total++;
    if (inst_pc !== 32'h0 || inst_exc_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL rst_pc_exc got=%h/%b want=0/0",
               inst_pc, inst_exc_misaligned);
    end
    @(posedge clk);
    #1 resetb = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] ga[$];
    logic [31:0] hp[$];
    logic [31:0] hi[$];
    int gc[$];
    int hc[$];
    int t;
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    for (int n = 0; n < 40 && hp.size() < 2; n++) begin
      t = cyc;
      step(1'b1, 1'b0, '0, 1'b0, '0);
      if (s_gnt) begin ga.push_back(s_addr); gc.push_back(t); end
      if (s_hs) begin
        hp.push_back(s_pc); hi.push_back(s_inst); hc.push_back(t);
      end
    end
    total++;
    if (hp.size() < 2 || ga.size() < 2) begin
      bad++;
      $display("FAIL basic_count got=%0d/%0d want=2/2", ga.size(), hp.size());
    end else begin
      total++;
      if (ga[0] !== 32'h0 || ga[1] !== 32'h4) begin
        bad++; $display("FAIL basic_addr got=%h,%h want=0,4", ga[0], ga[1]);
      end
      total++;
      if (hp[0] !== 32'h0 || hi[0] !== 32'h0050_0093) begin
        bad++; $display("FAIL basic_i0 got=%h@%h want=00500093@0", hi[0], hp[0]);
      end
      total++;
      if (hp[1] !== 32'h4 || hi[1] !== 32'h00A0_0113) begin
        bad++; $display("FAIL basic_i1 got=%h@%h want=00a00113@4", hi[1], hp[1]);
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (hc[k] - gc[k] !== 2) begin
          bad++; $display("FAIL basic_lat%0d got=%0d want=2", k, hc[k] - gc[k]);
        end
      end
    end
  endtask

  task automatic wait_gnt(input bit rdy, input string nm, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      step(rdy, 1'b0, '0, 1'b0, '0);
      ok = s_gnt;
      n++;
    end
    if (!ok) begin
      total++; bad++; $display("FAIL %s gnt timeout got=none want=gnt", nm);
    end
  endtask

  task automatic wait_hs(input bit rdy, input string nm, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      step(rdy, 1'b0, '0, 1'b0, '0);
      ok = rdy ? s_hs : s_valid;
      n++;
    end
    if (!ok) begin
      total++; bad++; $display("FAIL %s valid timeout got=none want=valid", nm);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    int n;
    lat_min = 1; lat_max = 1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      step(1'b1, 1'b0, '0, 1'b0, '0);
      ok = s_gnt && (s_addr == 32'h8);
      n++;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL redir_setup got=none want=gnt@8");
    end else begin
      step(1'b1, 1'b1, 32'h100, 1'b0, '0);
      wait_gnt(1'b1, "redir", ok);
      if (ok) begin
        total++;
        if (s_addr !== 32'h100) begin
          bad++; $display("FAIL redir_addr got=%h want=100", s_addr);
        end
      end
      wait_hs(1'b1, "redir", ok);
      if (ok) begin
        total++;
        if (s_pc !== 32'h100 || s_inst !== mem_word(32'h100)) begin
          bad++;
          $display("FAIL redir_inst got=%h@%h want=%h@100",
                   s_inst, s_pc, mem_word(32'h100));
        end
      end
    end
  endtask

  task automatic test_hold();
    bit ok;
    logic [31:0] vi, vp;
    lat_min = 0; lat_max = 0;
    wait_hs(1'b0, "hold", ok);
    if (ok) begin
      vi = s_inst;
      vp = s_pc;
      total++;
      if (vp !== 32'h104 || vi !== mem_word(32'h104)) begin
        bad++; $display("FAIL hold_first got=%h@%h want=%h@104",
                        vi, vp, mem_word(32'h104));
      end
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 1'b0, '0, 1'b0, '0);
        total++;
        if (!s_valid || s_inst !== vi || s_pc !== vp || s_req) begin
          bad++;
          $display("FAIL hold_stable%0d got=v%b %h@%h req%b want=v1 %h@%h req0",
                   k, s_valid, s_inst, s_pc, s_req, vi, vp);
        end
      end
      step(1'b1, 1'b0, '0, 1'b0, '0);
      total++;
      if (!s_hs) begin
        bad++; $display("FAIL hold_hs got=%b want=1", s_hs);
      end
      wait_gnt(1'b0, "hold", ok);
      if (ok) begin
        total++;
        if (s_addr !== 32'h108) begin
          bad++; $display("FAIL hold_next got=%h want=108", s_addr);
        end
      end
    end
  endtask

  task automatic test_trap();
    bit ok;
    wait_hs(1'b0, "trap", ok);
    if (ok) begin
      step(1'b0, 1'b1, 32'h200, 1'b1, 32'h40);
      wait_gnt(1'b1, "trap", ok);
      if (ok) begin
        total++;
        if (s_addr !== 32'h40) begin
          bad++; $display("FAIL trap_addr got=%h want=40", s_addr);
        end
      end
      wait_hs(1'b1, "trap", ok);
      if (ok) begin
        total++;
        if (s_pc !== 32'h40 || s_inst !== mem_word(32'h40)) begin
          bad++; $display("FAIL trap_inst got=%h@%h want=%h@40",
                          s_inst, s_pc, mem_word(32'h40));
        end
      end
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    int reqs;
    wait_hs(1'b0, "mis", ok);
    if (ok) begin
      step(1'b0, 1'b1, 32'h102, 1'b0, '0);
      reqs = 0;
      ok = 1'b0;
      for (int n = 0; n < 10 && !ok; n++) begin
        step(1'b0, 1'b0, '0, 1'b0, '0);
        if (s_req) reqs++;
        ok = s_valid;
      end
      total++;
      if (!ok || reqs != 0) begin
        bad++; $display("FAIL mis_noreq got=v%b req%0d want=v1 req0", ok, reqs);
      end
      total++;
      if (s_inst !== NOP || s_pc !== 32'h102 || s_exc !== 1'b1) begin
        bad++; $display("FAIL mis_nop got=%h@%h e%b want=%h@102 e1",
                        s_inst, s_pc, s_exc, NOP);
      end
      step(1'b1, 1'b0, '0, 1'b0, '0);
      total++;
      if (!s_hs) begin
        bad++; $display("FAIL mis_hs got=%b want=1", s_hs);
      end
      reqs = 0;
      repeat (8) begin
        step(1'b1, 1'b0, '0, 1'b0, '0);
        if (s_req || s_valid) reqs++;
      end
      total++;
      if (reqs != 0) begin
        bad++; $display("FAIL mis_stop got=%0d busy cycles want=0", reqs);
      end
      step(1'b1, 1'b1, 32'h0, 1'b0, '0);
      wait_gnt(1'b1, "mis", ok);
      if (ok) begin
        total++;
        if (s_addr !== 32'h0) begin
          bad++; $display("FAIL mis_resume got=%h want=0", s_addr);
        end
      end
      wait_hs(1'b1, "mis", ok);
      if (ok) begin
        total++;
        if (s_pc !== 32'h0 || s_inst !== 32'h0050_0093 || s_exc !== 1'b0) begin
          bad++; $display("FAIL mis_inst got=%h@%h e%b want=00500093@0 e0",
                          s_inst, s_pc, s_exc);
        end
      end
    end
  endtask

  task automatic test_reset_wait();
    bit ok;
    lat_min = 2; lat_max = 2;
    wait_gnt(1'b1, "rstw", ok);
    if (ok) begin
      resetb = 1'b0;
      m_busy = 1'b0;
      im_gnt = 0; im_rvalid = 0; redirect = 0; trap = 0;
      @(posedge clk);
      #1;
      total++;
      if (inst_valid !== 1'b0 || im_req !== 1'b0 || inst_pc !== 32'h0) begin
        bad++; $display("FAIL rstw_state got=v%b r%b pc%h want=v0 r0 pc0",
                        inst_valid, im_req, inst_pc);
      end
      @(posedge clk);
      #1;
      resetb = 1'b1;
      lat_min = 0; lat_max = 0;
      m_busy = 1'b1;
      m_wait = 0;
      m_addr = 32'hBAD0;
      wait_gnt(1'b1, "rstw", ok);
      if (ok) begin
        total++;
        if (s_addr !== 32'h0) begin
          bad++; $display("FAIL rstw_addr got=%h want=0", s_addr);
        end
      end
      wait_hs(1'b1, "rstw", ok);
      if (ok) begin
        total++;
        if (s_pc !== 32'h0 || s_inst !== 32'h0050_0093) begin
          bad++; $display("FAIL rstw_inst got=%h@%h want=00500093@0",
                          s_inst, s_pc);
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_tgt();
    int r;
    logic [31:0] a;
    r = int'($urandom_range(99));
    if (r < 8) a = 32'hFFFF_FFF0;
    else a = 32'($urandom_range(1023)) << 2;
    if (r >= 90) a = a + 32'($urandom_range(3, 1));
    return a;
  endfunction

  task automatic test_random();
    logic [31:0] exp_pc, rpc, tpc, want_i, prev_addr;
    bit stopped, was_stopped, rdy, rd, tr, prev_req, prev_gnt, exp_exc;
    int hs_cnt;
    gnt_pct = 60; lat_min = 0; lat_max = 2;
    step(1'b0, 1'b1, 32'h300, 1'b0, '0);
    exp_pc = 32'h300;
    stopped = 1'b0;
    prev_req = s_req; prev_gnt = s_gnt; prev_addr = s_addr;
    hs_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      rdy = int'($urandom_range(99)) < 70;
      rd = 1'b0;
      tr = 1'b0;
      if (int'($urandom_range(99)) < (stopped ? 20 : 4)) begin
        tr = $urandom_range(1) == 1;
        rd = !tr || ($urandom_range(1) == 1);
      end
      rpc = rand_tgt();
      tpc = rand_tgt();
      was_stopped = stopped;
      step(rdy, rd, rpc, tr, tpc);
      if (prev_req && !prev_gnt) begin
        total++;
        if (!s_req || s_addr !== prev_addr) begin
          bad++; $display("FAIL rnd_req_hold got=r%b %h want=r1 %h",
                          s_req, s_addr, prev_addr);
        end
      end
      if (was_stopped) begin
        total++;
        if (s_req) begin
          bad++; $display("FAIL rnd_stop got=req1 want=req0 at %h", s_addr);
        end
      end
      if (s_hs) begin
        hs_cnt++;
        exp_exc = exp_pc[1:0] != 2'b00;
        want_i = exp_exc ? NOP : mem_word(exp_pc);
        total++;
        if (s_pc !== exp_pc || s_inst !== want_i || s_exc !== exp_exc) begin
          bad++; $display("FAIL rnd_inst got=%h@%h e%b want=%h@%h e%b",
                          s_inst, s_pc, s_exc, want_i, exp_pc, exp_exc);
        end
        if (exp_exc) stopped = 1'b1;
        else exp_pc = exp_pc + 32'd4;
      end
      if (rd || tr) begin
        exp_pc = tr ? tpc : rpc;
        stopped = 1'b0;
      end
      prev_req = s_req; prev_gnt = s_gnt; prev_addr = s_addr;
    end
    total++;
    if (hs_cnt < 100) begin
      bad++; $display("FAIL rnd_progress got=%0d want>=100", hs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_redirect_wait();
    test_hold();
    test_trap();
    test_misaligned();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
